// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: runs one ALU transaction per rx command and ships the result byte to the UART tx core.
// Optional feature: define ALU_SEQ_STATUS_EN to append a status byte after each result byte.
module alu_uart_sequencer #(
    parameter int DATA_BITS   = 8,
    parameter int OPCODE_BITS = 6,
    parameter int ALU_LATENCY = 1,
    parameter int TX_TIMEOUT  = 4096
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_operation_ready,
    input  logic [DATA_BITS-1:0]   i_operando1,
    input  logic [DATA_BITS-1:0]   i_operando2,
    input  logic [OPCODE_BITS-1:0] i_opcode,
    output logic [DATA_BITS-1:0]   o_alu_a,
    output logic [DATA_BITS-1:0]   o_alu_b,
    output logic [OPCODE_BITS-1:0] o_alu_op,
    input  logic [DATA_BITS-1:0]   i_alu_result,
    output logic [DATA_BITS-1:0]   o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_overrun,
    output logic                   o_timeout
);
    localparam int TW = $clog2(TX_TIMEOUT);

`ifdef ALU_SEQ_STATUS_EN
    typedef enum logic [1:0] {IDLE, EXEC, WAIT_TX, STATUS_TX} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, WAIT_TX} state_t;
`endif

    state_t                 state_q, state_d;
    logic [3:0]             lat_q, lat_d;
    logic [TW-1:0]          to_q, to_d, to_inc;
    logic [DATA_BITS-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d, tx_data_q, tx_data_d;
    logic [OPCODE_BITS-1:0] alu_op_q, alu_op_d;
    logic                   tx_start_q, tx_start_d, overrun_q, overrun_d, timeout_q, timeout_d;

    assign to_inc = (to_q == '1) ? to_q : to_q + 1'b1;

`ifdef ALU_SEQ_STATUS_EN
    logic [DATA_BITS-1:0] status_byte;
    assign status_byte = {{(DATA_BITS-4){1'b0}}, timeout_q, overrun_q, tx_data_q[DATA_BITS-1], tx_data_q == '0};
`endif

    // next-state and datapath: capture, latency countdown, tx handshake with timeout
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        to_d       = to_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        timeout_d  = timeout_q;
        overrun_d  = overrun_q | (i_operation_ready && state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (i_operation_ready) begin
                    alu_a_d  = i_operando1;
                    alu_b_d  = i_operando2;
                    alu_op_d = i_opcode;
                    lat_d    = 4'(ALU_LATENCY);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (lat_q == 4'd1) begin
                    tx_data_d  = i_alu_result;
                    tx_start_d = 1'b1;
                    to_d       = '0;
                    state_d    = WAIT_TX;
                end else begin
                    lat_d = (lat_q == 4'd0) ? lat_q : lat_q - 4'd1;
                end
            end
            default: begin
                to_d = to_inc;
                if (!tx_start_q && i_tx_done) begin
`ifdef ALU_SEQ_STATUS_EN
                    if (state_q == WAIT_TX) begin
                        tx_data_d  = status_byte;
                        tx_start_d = 1'b1;
                        to_d       = '0;
                        state_d    = STATUS_TX;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else if (to_inc == TW'(TX_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    // state register; reset clears everything immediately, including the tx start strobe
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            to_q       <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            to_q       <= to_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = state_q != IDLE;
    assign o_overrun  = overrun_q;
    assign o_timeout  = timeout_q;
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb_alu_uart_sequencer: two instances (ALU_LATENCY 1 and 3, TX_TIMEOUT 16) checked every cycle against a transaction-level model.
module tb_alu_uart_sequencer;
    localparam int TO = 16;
`ifdef ALU_SEQ_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ready = 1'b0;
    logic       done = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [5:0] op = '0;

    logic [7:0] alu_a[2], alu_b[2], alu_res[2], tx_data[2];
    logic [5:0] alu_op[2];
    logic       tx_start[2], busy[2], overrun[2], timeout[2];

    logic [7:0] ea[2], eb[2], etx[2];
    logic [5:0] eop[2];
    logic       es[2], eovr[2], eto[2];
    int         st[2], n[2];
    int         n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu(logic [7:0] x, logic [7:0] y, logic [5:0] o);
        case (o)
            6'h20:   return x + y;
            6'h22:   return x - y;
            6'h24:   return x & y;
            6'h25:   return x | y;
            default: return x ^ y;
        endcase
    endfunction

    function automatic int lat(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign alu_res[g] = alu(alu_a[g], alu_b[g], alu_op[g]);
        alu_uart_sequencer #(.DATA_BITS(8), .OPCODE_BITS(6), .ALU_LATENCY(g == 0 ? 1 : 3), .TX_TIMEOUT(TO)) dut (
            .i_clk(clk), .i_rst(rst), .i_operation_ready(ready),
            .i_operando1(a), .i_operando2(b), .i_opcode(op),
            .o_alu_a(alu_a[g]), .o_alu_b(alu_b[g]), .o_alu_op(alu_op[g]),
            .i_alu_result(alu_res[g]), .o_tx_data(tx_data[g]), .o_tx_start(tx_start[g]),
            .i_tx_done(done), .o_busy(busy[g]), .o_overrun(overrun[g]), .o_timeout(timeout[g])
        );
    end

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ea[k] = '0; eb[k] = '0; eop[k] = '0; etx[k] = '0;
            es[k] = 1'b0; eovr[k] = 1'b0; eto[k] = 1'b0; st[k] = 0; n[k] = 0;
        end
    endtask

    // phases: 0 idle, 1 waiting for the ALU, 2 result byte on the wire, 3 status byte on the wire
    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            logic       ps;
            logic [7:0] sb;
            int         so;
            ps = es[k];
            so = st[k];
            sb = {4'b0, eto[k], eovr[k], etx[k][7], etx[k] == 8'h00};
            es[k] = 1'b0;
            if (so == 0) begin
                if (ready) begin
                    ea[k] = a; eb[k] = b; eop[k] = op; st[k] = 1; n[k] = 0;
                end
            end else if (so == 1) begin
                n[k]++;
                if (n[k] == lat(k)) begin
                    etx[k] = alu(ea[k], eb[k], eop[k]); es[k] = 1'b1; st[k] = 2; n[k] = 0;
                end
            end else begin
                n[k]++;
                if (!ps && done) begin
                    if (STATUS && so == 2) begin
                        etx[k] = sb; es[k] = 1'b1; st[k] = 3; n[k] = 0;
                    end else begin
                        st[k] = 0;
                    end
                end else if (n[k] == TO - 1) begin
                    eto[k] = 1'b1; st[k] = 0;
                end
            end
            if (ready && so != 0) eovr[k] = 1'b1;
        end
    endtask

    task automatic chk(string nm, int k, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            chk("alu_a", k, 16'(alu_a[k]), 16'(ea[k]));
            chk("alu_b", k, 16'(alu_b[k]), 16'(eb[k]));
            chk("alu_op", k, 16'(alu_op[k]), 16'(eop[k]));
            chk("tx_data", k, 16'(tx_data[k]), 16'(etx[k]));
            chk("tx_start", k, 16'(tx_start[k]), 16'(es[k]));
            chk("busy", k, 16'(busy[k]), 16'(st[k] != 0));
            chk("overrun", k, 16'(overrun[k]), 16'(eovr[k]));
            chk("timeout", k, 16'(timeout[k]), 16'(eto[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        #1;
    endtask

    task automatic cmd(logic [7:0] x, logic [7:0] y, logic [5:0] o);
        ready = 1'b1; a = x; b = y; op = o;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        model_reset();
        repeat (2) tick();
        chk("rst_busy", 0, 16'(busy[0]), 16'h0);
        chk("rst_tx_start", 1, 16'(tx_start[1]), 16'h0);
        rst = 1'b0;
        tick();
        // ADD 5+3: both instances capture on the same edge
        cmd(8'h05, 8'h03, 6'h20);
        chk("cap_a", 0, 16'(alu_a[0]), 16'h05);
        chk("cap_b", 0, 16'(alu_b[0]), 16'h03);
        chk("cap_op", 0, 16'(alu_op[0]), 16'h20);
        chk("cap_busy", 0, 16'(busy[0]), 16'h1);
        tick();
        chk("add_start", 0, 16'(tx_start[0]), 16'h1);
        chk("add_data", 0, 16'(tx_data[0]), 16'h08);
        tick();
        chk("add_start_drop", 0, 16'(tx_start[0]), 16'h0);
        chk("lat3_early", 1, 16'(tx_start[1]), 16'h0);
        tick();
        chk("lat3_start", 1, 16'(tx_start[1]), 16'h1);
        chk("lat3_data", 1, 16'(tx_data[1]), 16'h08);
        done = 1'b1;
        repeat (5) tick();
        chk("idle_after_done", 0, 16'(busy[0]), 16'h0);
        // SUB 0x10-0x01 with latency 3
        cmd(8'h10, 8'h01, 6'h22);
        tick();
        tick();
        chk("sub_early", 1, 16'(tx_start[1]), 16'h0);
        tick();
        chk("sub_start", 1, 16'(tx_start[1]), 16'h1);
        chk("sub_data", 1, 16'(tx_data[1]), 16'h0F);
        tick();
        chk("sub_one_pulse", 1, 16'(tx_start[1]), 16'h0);
        repeat (4) tick();
        // overrun during WAIT_TX; dropped command must not reach the ALU inputs
        done = 1'b0;
        cmd(8'h11, 8'h22, 6'h20);
        repeat (2) tick();
        cmd(8'hAA, 8'hBB, 6'h26);
        chk("ovr_set", 0, 16'(overrun[0]), 16'h1);
        chk("ovr_keep_a", 0, 16'(alu_a[0]), 16'h11);
        done = 1'b1;
        repeat (8) tick();
        chk("ovr_sticky", 0, 16'(overrun[0]), 16'h1);
        chk("ovr_keep_b", 0, 16'(alu_b[0]), 16'h22);
        // timeout with done held low
        done = 1'b0;
        cmd(8'h01, 8'h02, 6'h20);
        repeat (16) tick();
        chk("to_set", 0, 16'(timeout[0]), 16'h1);
        chk("to_idle", 0, 16'(busy[0]), 16'h0);
        repeat (3) tick();
        chk("to_set", 1, 16'(timeout[1]), 16'h1);
        done = 1'b1;
        cmd(8'h30, 8'h0F, 6'h20);
        tick();
        chk("after_to_start", 0, 16'(tx_start[0]), 16'h1);
        chk("after_to_data", 0, 16'(tx_data[0]), 16'h3F);
        repeat (8) tick();
        // asynchronous reset while tx_start is high
        done = 1'b0;
        cmd(8'h44, 8'h55, 6'h26);
        tick();
        chk("pre_rst_start", 0, 16'(tx_start[0]), 16'h1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_start", 0, 16'(tx_start[0]), 16'h0);
        chk("arst_busy", 0, 16'(busy[0]), 16'h0);
        chk("arst_a", 0, 16'(alu_a[0]), 16'h00);
        chk("arst_data", 0, 16'(tx_data[0]), 16'h00);
        chk("arst_ovr", 0, 16'(overrun[0]), 16'h0);
        chk("arst_to", 0, 16'(timeout[0]), 16'h0);
        tick();
        rst = 1'b0;
        tick();
        done = 1'b1;
        cmd(8'h07, 8'h0F, 6'h24);
        tick();
        chk("post_rst_start", 0, 16'(tx_start[0]), 16'h1);
        chk("post_rst_data", 0, 16'(tx_data[0]), 16'h07);
        repeat (8) tick();
        // randomized traffic: done random, stuck low, or stuck high in turns
        for (int i = 0; i < 3000; i++) begin
            int mode;
            mode = (i / 400) % 3;
            ready = ($urandom % 4) == 0;
            a = 8'($urandom);
            b = 8'($urandom);
            op = ($urandom % 2) ? 6'(6'h20 + 6'($urandom % 7)) : 6'($urandom);
            done = (mode == 0) ? (($urandom % 3) == 0) : (mode == 2);
            rst = ($urandom % 600) == 0;
            if (rst) model_reset();
            tick();
        end
        rst = 1'b0;
        ready = 1'b0;
        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
